// File: rtl/decod_rr_sched_pkg.sv
// Shared constants, FSM state type and round-robin pick for decod_rr_sched.
package decod_rr_sched_pkg;

    localparam int N_REQ = 16;
    localparam int IDX_W = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } rr_state_e;

    // First set request bit at or above ptr, wrapping from N_REQ-1 back to 0.
    function automatic void rr_pick(
        input  logic [N_REQ-1:0] req,
        input  logic [IDX_W-1:0] ptr,
        output logic [IDX_W-1:0] idx,
        output logic             found
    );
        logic [IDX_W-1:0] k;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            k = ptr + i[IDX_W-1:0];
            if (!found && req[k]) begin
                found = 1'b1;
                idx   = k;
            end
        end
    endfunction

endpackage

// File: rtl/decod_rr_sched_if.sv
// Requester/decoder-side bundle of decod_rr_sched; slave is the scheduler side.
interface decod_rr_sched_if
    import decod_rr_sched_pkg::*;
;
    logic [N_REQ-1:0] req;
    logic             done;
    logic [IDX_W-1:0] sel;
    logic             sel_en;
    logic [N_REQ-1:0] grant;
    logic             busy;
    logic             timeout;

    modport master (
        output req, done,
        input  sel, sel_en, grant, busy, timeout
    );

    modport slave (
        input  req, done,
        output sel, sel_en, grant, busy, timeout
    );
endinterface

// File: rtl/decod_rr_sched_4to16.sv
// Combinational 4-to-16 one-hot decoder with enable; mirrors the decoder datapath.
module decod_4to16
    import decod_rr_sched_pkg::*;
(
    input  logic [IDX_W-1:0] sel,
    input  logic             en,
    output logic [N_REQ-1:0] dout
);
    always_comb begin
        dout = '0;
        if (en) dout[sel] = 1'b1;
    end
endmodule

// File: rtl/decod_rr_sched.sv
// Round-robin scheduler driving the 16-way decoder select/enable.
// Optional forced release after TIMEOUT cycles: define DECOD_RR_SCHED_TIMEOUT_EN.
//
// state    | meaning
// ST_IDLE  | no holder; outputs low; arbitrate on req starting at ptr
// ST_GRANT | sel holds the winner; wait for done, dropped request or expiry
module decod_rr_sched
    import decod_rr_sched_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    decod_rr_sched_if.slave   bus
);
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("decod_rr_sched: TIMEOUT must be in 2..255");
    end

    rr_state_e        state_q, state_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic             sel_en_q, sel_en_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             rel_c;
    logic             expire;
    logic [N_REQ-1:0] grant_w;

    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        rr_pick(bus.req, ptr_q, pick_idx, pick_found);
    end

    assign rel_c = bus.done || !bus.req[sel_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            sel_en_q <= 1'b0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            sel_en_q <= sel_en_d;
            ptr_q    <= ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        sel_en_d = sel_en_q;
        ptr_d    = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d  = ST_GRANT;
                    sel_d    = pick_idx;
                    sel_en_d = 1'b1;
                end
            end
            ST_GRANT: begin
                if (rel_c || expire) begin
                    state_d  = ST_IDLE;
                    sel_d    = '0;
                    sel_en_d = 1'b0;
                    ptr_d    = sel_q + 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                sel_d    = '0;
                sel_en_d = 1'b0;
            end
        endcase
    end

`ifdef DECOD_RR_SCHED_TIMEOUT_EN
    logic [7:0] hold_cnt_q;
    logic       timeout_q;

    // Counter sits at zero in IDLE, so it is already clear on the first GRANT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
        end else if (state_q == ST_GRANT && !(rel_c || expire)) begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
        end else begin
            hold_cnt_q <= '0;
        end
    end

    assign expire = (state_q == ST_GRANT) && (hold_cnt_q == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) timeout_q <= 1'b0;
        else        timeout_q <= expire && !rel_c;
    end

    assign bus.timeout = timeout_q;
`else
    assign expire      = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    decod_4to16 u_dec (
        .sel  (sel_q),
        .en   (sel_en_q),
        .dout (grant_w)
    );

    assign bus.sel    = sel_q;
    assign bus.sel_en = sel_en_q;
    assign bus.grant  = grant_w;
    assign bus.busy   = (state_q == ST_GRANT);

endmodule

// File: tb/tb_decod_rr_sched.sv
// Bench for decod_rr_sched: reference model checked every cycle plus directed literal checks.
module tb_decod_rr_sched;
    import decod_rr_sched_pkg::*;

`ifdef DECOD_RR_SCHED_TIMEOUT_EN
    localparam int TO     = 4;
    localparam bit TO_EN  = 1'b1;
`else
    localparam int TO     = 64;
    localparam bit TO_EN  = 1'b0;
`endif

    logic clk;
    logic rst_n;
    decod_rr_sched_if bus ();

    decod_rr_sched #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_on = 1'b0;

    // Model: which requester holds the resource (-1 = none), pointer, hold cycles.
    int m_holder = -1;
    int m_ptr    = 0;
    int m_cnt    = 0;
    bit m_to     = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic logic [22:0] dut_vec();
        return {bus.sel, bus.sel_en, bus.grant, bus.busy, bus.timeout};
    endfunction

    function automatic logic [22:0] model_vec();
        logic [3:0]  s;
        logic [15:0] g;
        bit          h;
        h = (m_holder >= 0);
        s = h ? 4'(m_holder) : 4'd0;
        g = h ? (16'd1 << m_holder) : 16'd0;
        return {s, h, g, h, m_to};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_holder = -1;
            m_ptr    = 0;
            m_cnt    = 0;
            m_to     = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_holder < 0) begin
                m_cnt = 0;
                for (int i = 0; i < 16; i++) begin
                    if (m_holder < 0 && bus.req[(m_ptr + i) % 16]) m_holder = (m_ptr + i) % 16;
                end
            end else begin
                bit rel, exp_t;
                rel   = bus.done || !bus.req[m_holder];
                exp_t = TO_EN && (m_cnt == TO - 1);
                if (rel || exp_t) begin
                    m_to     = exp_t && !rel;
                    m_ptr    = (m_holder + 1) % 16;
                    m_holder = -1;
                    m_cnt    = 0;
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) chk("cycle", 32'(dut_vec()), 32'(model_vec()));
    end

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b1;
        bus.req  = '0;
        bus.done = 1'b0;
        #1 rst_n = 1'b0;
        chk_on   = 1'b1;
        repeat (3) nxt();
        chk("reset_outputs", 32'(dut_vec()), 32'd0);
        rst_n = 1'b1;

        // Single grant
        nxt();
        bus.req = 16'h0010;
        nxt();
        chk("single_sel", 32'(bus.sel), 32'd4);
        chk("single_grant", 32'(bus.grant), 32'h0010);
        chk("single_sel_en", 32'(bus.sel_en), 32'd1);
        bus.done = 1'b1;
        nxt();
        chk("single_release", 32'(bus.grant), 32'd0);
        chk("model_ptr_after_single", 32'(m_ptr), 32'd5);
        bus.done = 1'b0;
        bus.req  = '0;

        // Rotation from ptr=0
        rst_n = 1'b0;
        nxt();
        rst_n   = 1'b1;
        bus.req = 16'hFFFF;
        for (int i = 0; i < 17; i++) begin
            nxt();
            chk("rot_sel", 32'(bus.sel), 32'(i % 16));
            chk("rot_grant", 32'(bus.grant), 32'(16'd1 << (i % 16)));
            bus.done = 1'b1;
            nxt();
            chk("rot_gap", 32'(bus.grant), 32'd0);
            bus.done = 1'b0;
        end

        // Wrap search: move ptr to 14 by granting 13
        bus.req = 16'h2000;
        nxt();
        chk("wrap_prep_sel", 32'(bus.sel), 32'd13);
        bus.done = 1'b1;
        nxt();
        bus.done = 1'b0;
        chk("model_ptr_14", 32'(m_ptr), 32'd14);
        bus.req = 16'h0005;
        nxt();
        chk("wrap_sel0", 32'(bus.sel), 32'd0);
        bus.done = 1'b1;
        nxt();
        chk("wrap_gap", 32'(bus.grant), 32'd0);
        bus.done = 1'b0;
        nxt();
        chk("wrap_sel2", 32'(bus.sel), 32'd2);
        bus.done = 1'b1;
        nxt();
        bus.done = 1'b0;
        bus.req  = '0;

        // Request drop, with a newcomer ignored during the grant
        bus.req = 16'h0080;
        nxt();
        chk("drop_sel7", 32'(bus.sel), 32'd7);
        bus.req = 16'h0180;
        nxt();
        chk("drop_hold_sel7", 32'(bus.sel), 32'd7);
        bus.req = 16'h0100;
        nxt();
        chk("drop_release", 32'(bus.grant), 32'd0);
        chk("drop_no_timeout", 32'(bus.timeout), 32'd0);
        chk("model_ptr_8", 32'(m_ptr), 32'd8);
        nxt();
        chk("drop_next_sel8", 32'(bus.sel), 32'd8);
        bus.req = '0;
        nxt();

`ifdef DECOD_RR_SCHED_TIMEOUT_EN
        bus.req = 16'h0002;
        for (int i = 0; i < 4; i++) begin
            nxt();
            chk("to_held", 32'(bus.grant), 32'h0002);
        end
        nxt();
        chk("to_released", 32'(bus.grant), 32'd0);
        chk("to_pulse", 32'(bus.timeout), 32'd1);
        nxt();
        chk("to_regrant", 32'(bus.sel), 32'd1);
        chk("to_pulse_end", 32'(bus.timeout), 32'd0);
        repeat (3) nxt();
        bus.done = 1'b1;
        nxt();
        chk("to_done_wins_grant", 32'(bus.grant), 32'd0);
        chk("to_done_wins_pulse", 32'(bus.timeout), 32'd0);
        bus.done = 1'b0;
        bus.req  = '0;
        nxt();
`else
        bus.req = 16'h0002;
        repeat (70) nxt();
        chk("no_to_busy", 32'(bus.busy), 32'd1);
        chk("no_to_sel", 32'(bus.sel), 32'd1);
        bus.req = '0;
        nxt();
        chk("no_to_release", 32'(bus.grant), 32'd0);
`endif

        // Async reset mid-grant
        bus.req = 16'h0200;
        nxt();
        chk("arst_sel9", 32'(bus.sel), 32'd9);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_outputs", 32'(dut_vec()), 32'd0);
        chk("model_ptr_reset", 32'(m_ptr), 32'd0);
        nxt();
        rst_n = 1'b1;
        nxt();
        chk("arst_regrant_sel9", 32'(bus.sel), 32'd9);
        bus.done = 1'b1;
        nxt();
        bus.done = 1'b0;
        bus.req  = '0;
        repeat (2) nxt();

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
